// File: rtl/pipeline_pkg.sv
// Shared pipeline types: handshake pair, per-stage payload layouts and default
// widths used by the elastic stage registers between pipeline stages.
package pipeline_pkg;

  localparam int unsigned STALL_CNT_W_DEF = 16;
  localparam int unsigned XLEN            = 32;

  typedef struct packed {
    logic valid;
    logic ready;
  } stage_hs_t;

  // Stage payloads; instantiate a stage register with WIDTH = $bits(<type>)
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Val;
    logic [XLEN-1:0] rs2Val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [3:0]      aluOp;
    logic            memRead;
    logic            memWrite;
    logic            regWrite;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] aluRes;
    logic [XLEN-1:0] storeVal;
    logic [4:0]      rd;
    logic            memRead;
    logic            memWrite;
    logic            regWrite;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0] wbVal;
    logic [4:0]      rd;
    logic            regWrite;
  } mem_wr_t;

endpackage

// File: rtl/elastic_slot_ram.sv
// DEPTH x WIDTH register array: one indexed write port, one asynchronous
// indexed read port, contents cleared asynchronously on RST.
module elastic_slot_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [WIDTH-1:0] wrData,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wrEn) begin
      mem[wrIdx] <= wrData;
    end
  end

  assign rdData = mem[rdIdx];

endmodule

// File: rtl/elastic_stage_reg.sv
// Generic elastic pipeline stage register: in-order skid queue with
// valid/ready on both sides, synchronous flush and a saturating stall counter.
module elastic_stage_reg
  import pipeline_pkg::*;
#(
  parameter  int unsigned WIDTH       = 32,
  parameter  int unsigned DEPTH       = 2,
  parameter  int unsigned STALL_CNT_W = STALL_CNT_W_DEF,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [CNT_W-1:0]       count,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0]       wrPtr, rdPtr, wrPtrNext, rdPtrNext;
  logic [CNT_W-1:0]       countQ, countNext;
  logic [STALL_CNT_W-1:0] stallQ, stallNext;
  logic                   pushEn, popEn;

  // Wrap from DEPTH-1 to 0; DEPTH need not be a power of two
  function automatic logic [IDX_W-1:0] ptrInc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  assign in_ready  = (countQ != CNT_W'(DEPTH));
  assign out_valid = (countQ != '0);
  assign pushEn    = in_valid && in_ready && !flush;
  assign popEn     = out_valid && out_ready;
  assign count     = countQ;
  assign stall_cnt = stallQ;

  always_comb begin
    wrPtrNext = wrPtr;
    rdPtrNext = rdPtr;
    countNext = countQ;
    stallNext = stallQ;
    if (flush) begin
      wrPtrNext = '0;
      rdPtrNext = '0;
      countNext = '0;
    end else begin
      if (pushEn) wrPtrNext = ptrInc(wrPtr);
      if (popEn)  rdPtrNext = ptrInc(rdPtr);
      countNext = countQ + CNT_W'(pushEn) - CNT_W'(popEn);
    end
    if (out_valid && !out_ready && (stallQ != '1)) begin
      stallNext = stallQ + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
      stallQ <= '0;
    end else begin
      wrPtr  <= wrPtrNext;
      rdPtr  <= rdPtrNext;
      countQ <= countNext;
      stallQ <= stallNext;
    end
  end

  elastic_slot_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_slots (
    .CLK    (CLK),
    .RST    (RST),
    .wrEn   (pushEn),
    .wrIdx  (wrPtr),
    .wrData (in_data),
    .rdIdx  (rdPtr),
    .rdData (out_data)
  );

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(in_valid && in_ready && $isunknown(in_data)))
        else $error("in_data unknown on push");
      assert (countQ <= CNT_W'(DEPTH))
        else $error("occupancy above DEPTH");
    end
  end
`endif

endmodule
